dispense_sequencer: RTL
=======================

Name: dispense_sequencer

Overview:
Recipe-driven controller for the beverage dispenser's ingredient valves. On `start` it snapshots five dose values and opens each valve in fixed order: water, coffee, sugar, milk, chocolate. Each valve stays open for dose × PRESCALE clock cycles, then the block signals completion. It replaces free-running comparator stepping with timed, cancellable, pausable sequencing and sits between the front-panel/config registers and the valve drivers.

Parameters:
COUNT_W, 8, width of each dose value (dose units).
PRESCALE, 4, clock cycles per dose unit; legal range ≥1.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin a recipe; sampled only in IDLE.
cancel  in  1  abort the running recipe.
hold  in  1  pause: valves closed, timing frozen while high.
dose_water  in  COUNT_W  water dose units.
dose_coffee  in  COUNT_W  coffee dose units.
dose_sugar  in  COUNT_W  sugar dose units.
dose_milk  in  COUNT_W  milk dose units.
dose_chocolate  in  COUNT_W  chocolate dose units.
valve  out  5  one-hot valve enables; bit0 water … bit4 chocolate.
busy  out  1  recipe in progress.
done  out  1  one-cycle pulse on normal completion.
aborted  out  1  one-cycle pulse on cancel.
state_output  out  3  0–4 = current step, 5 = FINISHED, 6 = IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state goes to IDLE.
  - valve=0, busy=0, done=0, aborted=0, state_output=6, counters cleared.
  - Takes effect immediately, including mid-recipe.
- All outputs are registered.
- States: IDLE, STEP(k) for k=0..4, each with a DISPENSE and a GAP phase, and FINISHED.
- IDLE:
  - `start`=1 at edge t latches all five doses into internal registers.
  - At t+1 the block enters STEP(0): busy=1, valve[0]=1 (if dose ≠0).
  - Dose inputs are ignored after the latch.
- STEP(k) DISPENSE:
  - valve[k]=1 for exactly dose_k × PRESCALE consecutive non-hold cycles.
  - Implemented as a prescaler (PRESCALE−1 down to 0) plus a dose down-counter; no multiplier.
- STEP(k) GAP:
  - Exactly one cycle with valve=0 after DISPENSE.
  - A zero dose skips DISPENSE, so the step is the single GAP cycle only.
- Step advance:
  - After the GAP of k<4, go to STEP(k+1).
  - After the GAP of k=4, go to FINISHED.
- FINISHED: lasts one cycle with done=1, busy=1, state_output=5; next cycle goes to IDLE (busy=0).
- `hold`=1 in any STEP:
  - valve forced to 0 on the next edge.
  - prescaler, dose counter and GAP progression are frozen.
  - On release, dispensing resumes where it stopped; total open cycles are unchanged.
  - `hold` has no effect in IDLE or FINISHED.
- `cancel`=1 in STEP or FINISHED:
  - Next edge: valve=0, busy=0, aborted=1 for one cycle, state IDLE.
  - done is not asserted.
  - cancel overrides hold.
- `cancel`=1 in IDLE: ignored, no aborted pulse.
- `start` with `cancel` in IDLE: cancel wins; no recipe starts.
- `start` while busy: ignored; latched doses are unaffected.
- `start` held high continuously: a new recipe begins at the first IDLE cycle after FINISHED.
- Invariant: at most one valve bit is high at any time.
- Maximum dose: dose=2^COUNT_W−1 must time correctly, with no counter wrap.

Decomposition:
- Package dispense_pkg holds:
  - NUM_INGREDIENTS=5.
  - Step indices WATER..CHOCOLATE.
  - state_output codes FINISHED_CODE=3'd5 and IDLE_CODE=3'd6.
  - The FSM state enum.
- Sub-module dose_timer:
  - Contains the prescaler plus dose down-counter.
  - Ports: clock, reset, load, dose, enable (=!hold), expired.
  - One instance, reloaded at each step entry.

Test Plan:
1. PRESCALE=2, doses 3,0,1,0,2, start at cycle 0 -> water high cycles 1–6; coffee GAP only (cycle 8); sugar 9–10; milk GAP only (cycle 12); chocolate 13–16; done=1 at cycle 18; busy=0 from 19. Other checks:
   - GAP cycles 7, 11 and 17 have valve=0.
   - state_output tracks 0..5 then 6.
2. Same run with hold=1 during cycles 3–5 -> valve=0 in cycles 4–6 (hold sampled 3–5); water re-opens at cycle 7 for its remaining cycles; done is delayed by exactly 3 cycles to 21.
3. cancel=1 at cycle 10 of scenario 1 -> at cycle 11: valve=0, aborted=1, busy=0, state_output=6; done never pulses. A following start runs a full recipe normally.
4. All doses 0 -> five GAP cycles (1–5), done at cycle 6, valve never high.
5. Async reset low mid-chocolate -> valve=0 immediately without a clock edge; after release, start/cancel pressed together -> stays IDLE, no aborted pulse.
6. Dose inputs changed while busy, and start pulsed at cycle 4 -> timing follows the latched values; the second start is ignored. PRESCALE=1 with dose 255 -> valve high for exactly 255 cycles.

Source files
------------

// File: rtl/dispense_pkg.sv
// Shared definitions for the beverage dispenser valve sequencer.
package dispense_pkg;

  localparam int NUM_INGREDIENTS = 5;

  // Step indices, in dispensing order; also the valve bit each step drives.
  localparam logic [2:0] WATER     = 3'd0;
  localparam logic [2:0] COFFEE    = 3'd1;
  localparam logic [2:0] SUGAR     = 3'd2;
  localparam logic [2:0] MILK      = 3'd3;
  localparam logic [2:0] CHOCOLATE = 3'd4;

  // state_output codes outside the step range.
  localparam logic [2:0] FINISHED_CODE = 3'd5;
  localparam logic [2:0] IDLE_CODE     = 3'd6;

  // A recipe step is either dispensing (valve open) or in its one-cycle gap.
  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPENSE,
    S_GAP,
    S_FINISHED
  } state_t;

  // One-hot valve vector for a step index (caller guarantees step <= CHOCOLATE).
  function automatic logic [NUM_INGREDIENTS-1:0] step_onehot(input logic [2:0] step);
    return NUM_INGREDIENTS'(1) << step;
  endfunction

endpackage

// File: rtl/dispense_sequencer_dose_timer.sv
// Dose timer: PRESCALE-cycle prescaler chained to a dose-unit down-counter.
// After load, expired rises once dose*PRESCALE-1 enabled cycles have elapsed,
// i.e. during the last of dose*PRESCALE dispensing cycles.
module dose_timer #(
  parameter int COUNT_W  = 8,
  parameter int PRESCALE = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] dose,
  input  logic               enable,
  output logic               expired
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]   r_pre;
  logic [COUNT_W-1:0] r_dose;

  // Last remaining cycle: final dose unit with the prescaler exhausted.
  assign expired = (r_dose == COUNT_W'(1)) && (r_pre == '0);

  // Reload on step entry; otherwise count down while enabled, stopping at expiry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre  <= '0;
      r_dose <= '0;
    end else if (load) begin
      r_pre  <= PRE_MAX;
      r_dose <= dose;
    end else if (enable && !expired && (r_dose != '0)) begin
      if (r_pre == '0) begin
        r_pre  <= PRE_MAX;
        r_dose <= r_dose - COUNT_W'(1);
      end else begin
        r_pre  <= r_pre - PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/dispense_sequencer.sv
// Recipe-driven valve sequencer: water, coffee, sugar, milk, chocolate,
// each open for dose*PRESCALE cycles then a one-cycle gap; pausable by hold,
// abortable by cancel. All outputs are registered.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int COUNT_W  = 8,
  parameter int PRESCALE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       cancel,
  input  logic                       hold,
  input  logic [COUNT_W-1:0]         dose_water,
  input  logic [COUNT_W-1:0]         dose_coffee,
  input  logic [COUNT_W-1:0]         dose_sugar,
  input  logic [COUNT_W-1:0]         dose_milk,
  input  logic [COUNT_W-1:0]         dose_chocolate,
  output logic [NUM_INGREDIENTS-1:0] valve,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [2:0]                 state_output
);

  state_t             r_state;
  state_t             w_next_state;
  logic [2:0]         r_step;
  logic [2:0]         w_next_step;
  logic [2:0]         w_inc_step;
  logic [COUNT_W-1:0] r_doses [NUM_INGREDIENTS];
  logic               w_latch;
  logic               w_load;
  logic [COUNT_W-1:0] w_load_dose;
  logic               w_abort;
  logic               w_expired;
  logic               w_timer_en;
  logic               w_held;

  logic [NUM_INGREDIENTS-1:0] r_valve;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_aborted;
  logic [2:0]                 r_state_out;

  assign w_inc_step = r_step + 3'd1;

  // hold only matters once a recipe is running; FINISHED never re-enters a step.
  assign w_held = hold && (r_state != S_IDLE);

  // The timer advances only on non-hold dispensing cycles, so a pause neither
  // consumes nor adds open time.
  assign w_timer_en = !hold && (r_state == S_DISPENSE);

  dose_timer #(
    .COUNT_W  (COUNT_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (w_load),
    .dose    (w_load_dose),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  // Next-state logic: cancel beats everything, hold freezes a step in place.
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_load_dose  = dose_water;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !cancel) begin
          w_latch      = 1'b1;
          w_load       = 1'b1;
          w_load_dose  = dose_water;
          w_next_step  = WATER;
          w_next_state = (dose_water != '0) ? S_DISPENSE : S_GAP;
        end
      end
      S_DISPENSE: begin
        if (cancel) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (!hold && w_expired) begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (cancel) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (!hold) begin
          if (r_step == CHOCOLATE) begin
            w_next_state = S_FINISHED;
          end else begin
            w_next_step  = w_inc_step;
            w_load       = 1'b1;
            w_load_dose  = r_doses[w_inc_step];
            w_next_state = (r_doses[w_inc_step] != '0) ? S_DISPENSE : S_GAP;
          end
        end
      end
      S_FINISHED: begin
        w_abort      = cancel;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State and step registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= WATER;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
    end
  end

  // Recipe snapshot taken on an accepted start; untouched while busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INGREDIENTS; i++) r_doses[i] <= '0;
    end else if (w_latch) begin
      r_doses[0] <= dose_water;
      r_doses[1] <= dose_coffee;
      r_doses[2] <= dose_sugar;
      r_doses[3] <= dose_milk;
      r_doses[4] <= dose_chocolate;
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valve     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_state_out <= IDLE_CODE;
    end else begin
      r_valve     <= ((w_next_state == S_DISPENSE) && !w_held) ? step_onehot(w_next_step) : '0;
      r_busy      <= (w_next_state != S_IDLE);
      r_done      <= (w_next_state == S_FINISHED);
      r_aborted   <= w_abort;
      r_state_out <= (w_next_state == S_IDLE)     ? IDLE_CODE :
                     (w_next_state == S_FINISHED) ? FINISHED_CODE : w_next_step;
    end
  end

  assign valve        = r_valve;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign state_output = r_state_out;

endmodule
